// File: rtl/dynamic_branch_predictor_if.sv
// rtl/dynamic_branch_predictor_if.sv - fetch lookup and execute resolution signals of the branch predictor
interface dynamic_branch_predictor_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] PC_f;
  logic                  predict_taken_f;
  logic [DATA_WIDTH-1:0] predict_target_f;
  logic                  update_e;
  logic                  jump_e;
  logic                  taken_e;
  logic [DATA_WIDTH-1:0] PC_e;
  logic [DATA_WIDTH-1:0] target_e;
  logic [DATA_WIDTH-1:0] PCPlus4_e;
  logic                  pred_taken_e;
  logic [DATA_WIDTH-1:0] pred_target_e;
  logic                  mispredict_e;
  logic [DATA_WIDTH-1:0] correct_PC;

  modport slave (
    input  PC_f, update_e, jump_e, taken_e, PC_e, target_e, PCPlus4_e,
           pred_taken_e, pred_target_e,
    output predict_taken_f, predict_target_f, mispredict_e, correct_PC
  );

  modport master (
    output PC_f, update_e, jump_e, taken_e, PC_e, target_e, PCPlus4_e,
           pred_taken_e, pred_target_e,
    input  predict_taken_f, predict_target_f, mispredict_e, correct_PC
  );
endinterface

// File: rtl/dynamic_branch_predictor.sv
// rtl/dynamic_branch_predictor.sv - direct-mapped BTB with saturating counters and mispredict resolution
module dynamic_branch_predictor #(
  parameter int DATA_WIDTH = 32,
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 8,
  parameter int CNT_BITS   = 2
) (
  input logic clk,
  input logic rst,
  dynamic_branch_predictor_if.slave bp
);
  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [CNT_BITS-1:0] CNT_WT  = {1'b1, {(CNT_BITS-1){1'b0}}};
  localparam logic [CNT_BITS-1:0] CNT_WNT = CNT_WT - 1'b1;

  logic [ENTRIES-1:0]    valid_q;
  logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
  logic [DATA_WIDTH-1:0] target_q [ENTRIES];
  logic [CNT_BITS-1:0]   cnt_q    [ENTRIES];

  logic [INDEX_BITS-1:0] idx_f, idx_e;
  logic [TAG_BITS-1:0]   tag_f, tag_e;
  logic                  hit_f, hit_e;

  assign idx_f = bp.PC_f[INDEX_BITS+1:2];
  assign tag_f = bp.PC_f[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
  assign idx_e = bp.PC_e[INDEX_BITS+1:2];
  assign tag_e = bp.PC_e[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];

  // Lookup reads current state, so a same-cycle update is seen only next cycle
  assign hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

  assign bp.predict_taken_f  = hit_f && cnt_q[idx_f][CNT_BITS-1];
  assign bp.predict_target_f = bp.predict_taken_f ? target_q[idx_f]
                                                  : bp.PC_f + DATA_WIDTH'(4);

  always_comb begin
    bp.mispredict_e = 1'b0;
    bp.correct_PC   = bp.PCPlus4_e;
    if (bp.update_e) begin
      bp.mispredict_e = (bp.pred_taken_e != bp.taken_e) ||
                        (bp.taken_e && (bp.pred_target_e != bp.target_e));
      if (bp.taken_e) begin
        bp.correct_PC = bp.target_e;
      end
    end
  end

  logic                cnt_wr, tgt_wr;
  logic [CNT_BITS-1:0] cnt_d;

  always_comb begin
    cnt_wr = 1'b0;
    tgt_wr = 1'b0;
    cnt_d  = cnt_q[idx_e];
    if (bp.update_e) begin
      if (hit_e) begin
        cnt_wr = 1'b1;
        tgt_wr = bp.jump_e || bp.taken_e;
        if (bp.jump_e) begin
          cnt_d = CNT_MAX;
        end else if (bp.taken_e) begin
          cnt_d = (cnt_q[idx_e] == CNT_MAX) ? CNT_MAX : cnt_q[idx_e] + 1'b1;
        end else begin
          cnt_d = (cnt_q[idx_e] == '0) ? '0 : cnt_q[idx_e] - 1'b1;
        end
      end else if (bp.taken_e) begin
        // Allocation on miss evicts whatever alias held this index
        cnt_wr = 1'b1;
        tgt_wr = 1'b1;
        cnt_d  = bp.jump_e ? CNT_MAX : CNT_WT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        cnt_q[i] <= CNT_WNT;
      end
    end else if (cnt_wr) begin
      valid_q[idx_e] <= 1'b1;
      cnt_q[idx_e]   <= cnt_d;
    end
  end

  // Tags and targets are qualified by valid_q, so they need no reset
  always_ff @(posedge clk) begin
    if (tgt_wr) begin
      tag_q[idx_e]    <= tag_e;
      target_q[idx_e] <= bp.target_e;
    end
  end
endmodule

// File: doc/dynamic_branch_predictor.md
Name: dynamic_branch_predictor

Overview:
Parametrised dynamic branch predictor for the pipelined core. It replaces static prediction with a direct-mapped branch target buffer (BTB) plus per-entry saturating counters. Lookup is combinational on the fetch-stage PC; the table is updated from the execute stage. The block also resolves mispredictions, producing the flush request and the corrected PC for the fetch stage.

Parameters:
DATA_WIDTH, 32, width of PC and target addresses
INDEX_BITS, 6, log2 of BTB entries (default 64 entries)
TAG_BITS, 8, PC tag bits stored per entry
CNT_BITS, 2, saturating counter width (>=2)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
PC_f  input  DATA_WIDTH  fetch-stage PC for lookup
predict_taken_f  output  1  predict taken for PC_f
predict_target_f  output  DATA_WIDTH  predicted target; PC_f+4 when not predicted taken
update_e  input  1  execute stage holds a resolved branch/jump this cycle
jump_e  input  1  resolved instruction is an unconditional jump
taken_e  input  1  actual outcome (jumps are taken_e=1)
PC_e  input  DATA_WIDTH  PC of resolved instruction
target_e  input  DATA_WIDTH  actual computed target
PCPlus4_e  input  DATA_WIDTH  fall-through address
pred_taken_e  input  1  prediction made at fetch, carried down the pipeline
pred_target_e  input  DATA_WIDTH  predicted target, carried down the pipeline
mispredict_e  output  1  flush fetch/decode and redirect
correct_PC  output  DATA_WIDTH  redirect address

Behaviour:
- Index = PC[INDEX_BITS+1:2]; tag = PC[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2].
- Each entry holds valid, tag, target (DATA_WIDTH) and counter (CNT_BITS). Weak-taken (WT) = 2^(CNT_BITS-1); weak-not-taken (WNT) = WT-1; max = all ones.
- Reset (asynchronous, rst=1): all valid bits cleared, all counters set to WNT. Targets and tags are don't-care.
- Lookup is combinational with zero latency. hit = valid && tag match. predict_taken_f = hit && counter MSB. predict_target_f = stored target if predict_taken_f, else PC_f+4.
- Resolution is combinational. When update_e=0: mispredict_e=0 and correct_PC=PCPlus4_e.
- When update_e=1: mispredict_e = (pred_taken_e != taken_e) || (taken_e && pred_target_e != target_e). correct_PC = taken_e ? target_e : PCPlus4_e.
- Table update is sequential, on the clock edge when update_e=1, at the entry indexed by PC_e:
  - Hit, jump_e=1: counter set to max, target rewritten.
  - Hit, conditional: taken increments the counter, saturating at max; not-taken decrements it, saturating at 0. Target rewritten when taken.
  - Miss, taken_e=1: entry allocated (overwrites any alias). valid=1, tag and target written, counter = max if jump_e else WT.
  - Miss, taken_e=0: no change.
- Same-index lookup and update in one cycle: lookup returns the pre-update contents (read-before-write). The new value is visible from the next cycle.
- update_e=0: the table holds its contents.
- Reset mid-operation: all table state is cleared immediately. Outputs follow the combinational rules on cleared state, so predict_taken_f=0.
- Behaviour is independent of PC bits [1:0].

Test Plan:
- Reset, then PC_f=0x100 -> predict_taken_f=0, predict_target_f=0x104.
- Resolve a taken conditional branch: update_e=1, PC_e=0x100, target_e=0x180, pred_taken_e=0 -> mispredict_e=1, correct_PC=0x180. Next cycle PC_f=0x100 -> predict_taken_f=1, target 0x180 (counter=2).
- Entry at 0x100 with counter=2: two not-taken resolutions -> counter 1 then 0; predict_taken_f=0 after the first. A third not-taken resolution holds the counter at 0. Four taken resolutions -> counter 1,2,3,3 (saturates).
- Alias: entry at 0x100 valid; resolve taken PC_e=0x200 (same index 0, tag 2) -> lookup 0x100 misses (predict 0x104), lookup 0x200 hits.
- Jump: jump_e=1, taken_e=1, PC_e=0x040, target_e=0x400, pred_taken_e=1, pred_target_e=0x3FC -> mispredict_e=1, correct_PC=0x400. The entry's counter becomes 3 and its target is updated to 0x400.
- Simultaneous lookup and update at the same index -> lookup shows old data that cycle and new data the following cycle. Asserting rst during the test -> predict_taken_f=0 for all PCs.
